// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I datapath: fetch/decode/execute sequencing with
// memory handshakes, wait-state timeout, trap handling and a retired-instruction counter.
module multicycle_control #(
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W   = 4,
   parameter int WAIT_MAX   = 15,
   parameter int CNT_W      = 32,
   parameter bit TRAP_EN    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instruction,
   input  logic                  imem_ready,
   input  logic                  dmem_ready,
   input  logic                  branch_taken,
   output logic                  imem_req,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic                  reg_write,
   output logic [REG_ADDR_W-1:0] reg_waddr,
   output logic [ALU_OP_W-1:0]   alu_op,
   output logic [1:0]            alu_a_sel,
   output logic                  alu_b_imm,
   output logic [1:0]            wb_sel,
   output logic                  pc_write,
   output logic [2:0]            pc_sel,
   output logic                  trap,
   output logic [1:0]            trap_cause,
   output logic [CNT_W-1:0]      retired
);

   localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       ir_q, ir_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [1:0]        cause_q, cause_d;

   logic [6:0] opc;
   logic [2:0] f3;
   logic       rd_nz;
   logic       exec_legal;
   logic [3:0] alu_op4;
   logic       ir_unused;

   assign opc       = ir_q[6:0];
   assign f3        = ir_q[14:12];
   assign rd_nz     = (ir_q[11:7] != 5'd0);
   assign ir_unused = ^{ir_q[31], ir_q[29:15]};
   assign exec_legal = (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
                       (opc == OPC_LUI) || (opc == OPC_AUIPC);

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      cause_d   = cause_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               ir_d    = instruction;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opc)
               OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: state_d = S_EXEC;
               OPC_LOAD, OPC_STORE: begin
                  state_d = S_MEM;
                  wait_d  = '0;
               end
               OPC_BRANCH:        state_d = S_BRANCH;
               OPC_JAL, OPC_JALR: state_d = S_JUMP;
               default: begin
                  if (TRAP_EN) begin
                     state_d = S_TRAP;
                     cause_d = 2'd1;
                  end else begin
                     state_d = S_EXEC;
                  end
               end
            endcase
         end
         S_EXEC, S_BRANCH, S_JUMP: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         S_MEM: begin
            // A ready on the limit cycle still completes the access.
            if (dmem_ready) begin
               retired_d = retired_q + CNT_W'(1);
               state_d   = S_FETCH;
            end else if (TRAP_EN && (WAIT_MAX != 0) && (int'(wait_q) + 1 == WAIT_MAX)) begin
               state_d = S_TRAP;
               cause_d = 2'd2;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_TRAP:  state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         wait_q    <= '0;
         retired_q <= '0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         cause_q   <= cause_d;
      end
   end

   // Moore outputs from state and IR; MEM also looks at dmem_ready for its completing cycle.
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      alu_op4   = 4'd0;
      alu_a_sel = 2'd0;
      alu_b_imm = 1'b0;
      wb_sel    = 2'd0;
      pc_write  = 1'b0;
      pc_sel    = 3'd0;
      trap      = 1'b0;
      case (state_q)
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            pc_write = 1'b1;
            if (exec_legal) begin
               reg_write = rd_nz;
               alu_b_imm = (opc != OPC_OP);
               case (opc)
                  OPC_OP:     alu_op4 = {ir_q[30], f3};
                  OPC_OP_IMM: alu_op4 = {(f3 == 3'b101) & ir_q[30], f3};
                  OPC_LUI:    alu_a_sel = 2'd2;
                  OPC_AUIPC:  alu_a_sel = 2'd1;
                  default:    alu_op4 = 4'd0;
               endcase
            end
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = (opc == OPC_STORE);
            alu_b_imm = 1'b1;
            if (dmem_ready) begin
               pc_write = 1'b1;
               if (opc == OPC_LOAD) begin
                  reg_write = rd_nz;
                  wb_sel    = 2'd1;
               end
            end
         end
         S_BRANCH: begin
            alu_op4  = {1'b0, f3};
            pc_write = 1'b1;
            pc_sel   = branch_taken ? 3'd1 : 3'd0;
         end
         S_JUMP: begin
            reg_write = rd_nz;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            if (opc == OPC_JAL) begin
               pc_sel = 3'd2;
            end else begin
               pc_sel    = 3'd3;
               alu_b_imm = 1'b1;
            end
         end
         S_TRAP: begin
            trap     = 1'b1;
            pc_write = 1'b1;
            pc_sel   = 3'd4;
         end
         default: imem_req = 1'b0;
      endcase
   end

   assign alu_op     = ALU_OP_W'(alu_op4);
   assign reg_waddr  = (state_q == S_FETCH || state_q == S_DECODE) ? '0 : REG_ADDR_W'(ir_q[11:7]);
   assign trap_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one default instance plus a TRAP_EN=0 instance
// sharing the same stimulus.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instruction = '0;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;

   logic        imem_req, dmem_req, dmem_we, reg_write, alu_b_imm, pc_write, trap;
   logic [4:0]  reg_waddr;
   logic [3:0]  alu_op;
   logic [1:0]  alu_a_sel, wb_sel, trap_cause;
   logic [2:0]  pc_sel;
   logic [31:0] retired;

   logic        n_imem_req, n_dmem_req, n_dmem_we, n_reg_write, n_alu_b_imm, n_pc_write, n_trap;
   logic [4:0]  n_reg_waddr;
   logic [3:0]  n_alu_op;
   logic [1:0]  n_alu_a_sel, n_wb_sel, n_trap_cause;
   logic [2:0]  n_pc_sel;
   logic [31:0] n_retired;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_control u_dut (
      .clk(clk), .rst(rst), .instruction(instruction), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .reg_waddr(reg_waddr),
      .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_imm(alu_b_imm), .wb_sel(wb_sel),
      .pc_write(pc_write), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause),
      .retired(retired)
   );

   multicycle_control #(.TRAP_EN(1'b0)) u_dut_nt (
      .clk(clk), .rst(rst), .instruction(instruction), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(n_imem_req),
      .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .reg_write(n_reg_write),
      .reg_waddr(n_reg_waddr), .alu_op(n_alu_op), .alu_a_sel(n_alu_a_sel),
      .alu_b_imm(n_alu_b_imm), .wb_sel(n_wb_sel), .pc_write(n_pc_write), .pc_sel(n_pc_sel),
      .trap(n_trap), .trap_cause(n_trap_cause), .retired(n_retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; instruction = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Leaves both DUTs at the start of the cycle after DECODE.
   task automatic fetch_decode(input logic [31:0] ins);
      instruction = ins;
      imem_ready  = 1'b1;
      #1;
      chk("fetch_req", {imem_req, dmem_req, reg_write, pc_write}, 32'b1000);
      tick();
      imem_ready  = 1'b0;
      instruction = 32'hFFFF_FFFF;
      #1;
      chk("decode_quiet", {imem_req, dmem_req, reg_write, pc_write, trap, alu_op}, 32'd0);
      tick();
   endtask

   task automatic run_exec(input string tag, input logic [31:0] ins, input logic rw,
                           input logic [4:0] wa, input logic [3:0] op, input logic bimm,
                           input logic [1:0] asel, input logic [31:0] exp_ret);
      fetch_decode(ins);
      #1;
      chk({tag, "_rw"}, reg_write, rw);
      if (rw) chk({tag, "_waddr"}, reg_waddr, wa);
      chk({tag, "_aluop"}, alu_op, op);
      chk({tag, "_bimm_asel"}, {alu_b_imm, alu_a_sel}, {bimm, asel});
      chk({tag, "_pc"}, {pc_write, pc_sel, wb_sel}, {1'b1, 3'd0, 2'd0});
      tick();
      #1;
      chk({tag, "_retired"}, retired, exp_ret);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      #1;
      chk("rst_outputs", {imem_req, dmem_req, reg_write, pc_write, trap}, 32'b10000);
      chk("rst_retired", retired, 32'd0);
      chk("rst_cause", trap_cause, 32'd0);

      run_exec("add",    32'h002081B3, 1'b1, 5'd3, 4'b0000, 1'b0, 2'd0, 32'd1);
      run_exec("sub",    32'h403100B3, 1'b1, 5'd1, 4'b1000, 1'b0, 2'd0, 32'd2);
      run_exec("srai",   32'h4030D093, 1'b1, 5'd1, 4'b1101, 1'b1, 2'd0, 32'd3);
      run_exec("addi",   32'h40000093, 1'b1, 5'd1, 4'b0000, 1'b1, 2'd0, 32'd4);
      run_exec("lui",    32'h000012B7, 1'b1, 5'd5, 4'b0000, 1'b1, 2'd2, 32'd5);
      run_exec("addix0", 32'h00100013, 1'b0, 5'd0, 4'b0000, 1'b1, 2'd0, 32'd6);

      // LW x5,0(x1): three wait cycles, ready on the fourth
      fetch_decode(32'h0000A283);
      for (int i = 0; i < 3; i++) begin
         dmem_ready = 1'b0;
         #1;
         chk("lw_wait", {dmem_req, dmem_we, reg_write, wb_sel, pc_write}, 32'b100000);
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      chk("lw_done", {dmem_req, dmem_we, reg_write, wb_sel, pc_write}, 32'b101011);
      chk("lw_waddr", reg_waddr, 32'd5);
      tick();
      dmem_ready = 1'b0;
      #1;
      chk("lw_retired", retired, 32'd7);
      chk("lw_fetch", {imem_req, dmem_req}, 32'b10);

      // BEQ taken then not taken
      fetch_decode(32'h00208463);
      branch_taken = 1'b1;
      #1;
      chk("beq_t", {pc_write, pc_sel, reg_write, alu_op}, {24'd0, 1'b1, 3'd1, 1'b0, 4'd0});
      tick();
      branch_taken = 1'b0;
      fetch_decode(32'h00208463);
      #1;
      chk("beq_nt", {pc_write, pc_sel, reg_write}, {27'd0, 1'b1, 3'd0, 1'b0});
      tick();
      #1;
      chk("beq_retired", retired, 32'd9);

      // JAL x1
      fetch_decode(32'h008000EF);
      #1;
      chk("jal", {reg_write, reg_waddr, wb_sel, pc_write, pc_sel}, {20'd0, 1'b1, 5'd1, 2'd2, 1'b1, 3'd2});
      tick();
      #1;
      chk("jal_retired", retired, 32'd10);

      // SW with no ready: 15 wait cycles then a timeout trap
      fetch_decode(32'h0020A023);
      for (int i = 0; i < 15; i++) begin
         #1;
         chk("sw_wait", {dmem_req, dmem_we, reg_write, trap, pc_write}, 32'b11000);
         tick();
      end
      #1;
      chk("sw_trap", {trap, pc_write, pc_sel, reg_write}, {26'd0, 1'b1, 1'b1, 3'd4, 1'b0});
      chk("sw_cause_in_trap", trap_cause, 32'd2);
      tick();
      #1;
      chk("sw_after", {trap, imem_req, trap_cause}, 32'b0110);
      chk("sw_retired", retired, 32'd10);

      // Illegal opcode: trap on default instance, NOP on the TRAP_EN=0 instance
      do_reset();
      #1;
      chk("rst_cause_clear", trap_cause, 32'd0);
      fetch_decode(32'h0000007F);
      #1;
      chk("ill_trap", {trap, pc_write, pc_sel, reg_write, trap_cause}, {25'd0, 1'b1, 1'b1, 3'd4, 1'b0, 2'd1});
      chk("ill_nt", {n_trap, n_pc_write, n_pc_sel, n_reg_write}, {26'd0, 1'b0, 1'b1, 3'd0, 1'b0});
      tick();
      #1;
      chk("ill_retired", retired, 32'd0);
      chk("ill_nt_retired", n_retired, 32'd1);
      chk("ill_cause_hold", {trap, trap_cause}, 32'b001);

      // Reset in the middle of a load
      run_exec("add2", 32'h002081B3, 1'b1, 5'd3, 4'b0000, 1'b0, 2'd0, 32'd1);
      fetch_decode(32'h0000A283);
      #1;
      chk("mid_mem", dmem_req, 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_out", {imem_req, dmem_req, dmem_we, reg_write, pc_write, trap}, 32'b100000);
      chk("mid_rst_retired", retired, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised successor to the core's multi-cycle control FSM. It sequences FETCH, DECODE, EXECUTE/MEMORY/BRANCH/JUMP and TRAP for the RV32I datapath. Improvements over the current block:
- ready/req handshakes to instruction and data memory, with a configurable wait-state timeout;
- an internal instruction register;
- explicit PC-select and writeback-select encodings;
- rd==x0 write suppression;
- illegal-opcode trap handling;
- a retired-instruction counter.

Parameters:
- REG_ADDR_W, 5, width of register address (rd) output.
- ALU_OP_W, 4, width of alu_op; must be >=4; upper bits above bit 3 driven 0.
- WAIT_MAX, 15, maximum memory wait cycles before fault trap; 0 disables the timeout.
- CNT_W, 32, width of retired-instruction counter.
- TRAP_EN, 1, 1: illegal opcode/timeout enter TRAP; 0: illegal treated as NOP (PC+4), timeout waits forever.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-low reset
- instruction  in  32  instruction memory read data
- imem_ready  in  1  instruction fetch complete this cycle
- dmem_ready  in  1  data access complete this cycle
- branch_taken  in  1  comparator result from ALU, valid in BRANCH state
- imem_req  out  1  fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- reg_write  out  1  register file write enable
- reg_waddr  out  REG_ADDR_W  destination register
- alu_op  out  ALU_OP_W  ALU operation
- alu_a_sel  out  2  0 rs1, 1 PC, 2 zero
- alu_b_imm  out  1  1 selects immediate for ALU B
- wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
- pc_write  out  1  PC update enable
- pc_sel  out  3  0 PC+4, 1 branch target, 2 JAL target, 3 JALR target (ALU), 4 trap vector
- trap  out  1  pulses 1 cycle in TRAP
- trap_cause  out  2  0 none, 1 illegal opcode, 2 data timeout; holds until next trap or reset
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (rst==0 at edge): state FETCH, IR=0, wait counter 0, retired=0, trap_cause=0. All outputs are combinational from state+IR (Moore); in FETCH all outputs are 0 except imem_req=1.
- FETCH: imem_req=1. Stays until imem_ready=1, then IR<=instruction and next state is DECODE.
- DECODE: all outputs 0. Next state by IR[6:0]:
  - 0110011/0010011/0110111/0010111 -> EXEC
  - 0000011/0100011 -> MEM
  - 1100011 -> BRANCH
  - 1101111/1100111 -> JUMP
  - else -> TRAP if TRAP_EN, otherwise NOP: one EXEC cycle with reg_write=0.
- EXEC (1 cycle):
  - alu_op = {bit30, funct3}, where bit30=IR[30] for OP, and for OP_IMM only when funct3==101; otherwise 0.
  - LUI: alu_a_sel=2, alu_op=ADD(0). AUIPC: alu_a_sel=1, alu_op=ADD(0).
  - alu_b_imm=1 for all except OP.
  - reg_write=1 iff rd!=0; wb_sel=0; pc_write=1, pc_sel=0. Then FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 for store; alu_op=0, alu_b_imm=1. Stays until dmem_ready.
  - On the dmem_ready cycle, load asserts reg_write (rd!=0) with wb_sel=1; pc_write=1, pc_sel=0; then FETCH.
  - Wait counter increments each non-ready MEM cycle. If WAIT_MAX!=0 and the counter reaches WAIT_MAX with ready still 0: TRAP, cause 2, no register write.
  - dmem_ready in the same cycle as the limit wins; the access completes.
- BRANCH (1 cycle): alu_op={0,funct3}, pc_write=1, pc_sel = branch_taken ? 1 : 0. Then FETCH.
- JUMP (1 cycle): reg_write iff rd!=0, wb_sel=2, pc_write=1. JAL: pc_sel=2. JALR: pc_sel=3, alu_b_imm=1, alu_op=0. Then FETCH.
- TRAP (1 cycle): trap=1, pc_write=1, pc_sel=4, reg_write=0, trap_cause updated. Then FETCH. Not counted as retired.
- retired increments by 1 on the final cycle of EXEC, MEM-complete, BRANCH and JUMP, including NOP. Wraps modulo 2^CNT_W.
- reg_waddr = IR[11:7] zero-extended/truncated to REG_ADDR_W. IR changes only in FETCH on imem_ready.
- Wait counter clears on entry to MEM.
- Reset mid-instruction aborts immediately; no write or PC enable is asserted in the reset cycle's outputs after the edge.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ready on 1st cycle -> FETCH, DECODE, EXEC; EXEC has reg_write=1, reg_waddr=3, alu_op=0000, pc_sel=0; retired=1.
- LW x5,0(x1) (0x0000A283) with dmem_ready after 3 wait cycles -> dmem_req high 4 cycles; reg_write/wb_sel=1 only in the 4th; retired increments once.
- SW (0x0020A023) with dmem_ready never, WAIT_MAX=15 -> after 15 wait cycles TRAP, trap=1 for 1 cycle, trap_cause=2, pc_sel=4, dmem_we never writes back a register.
- BEQ (0x00208463): branch_taken=1 -> pc_sel=1; branch_taken=0 -> pc_sel=0; reg_write=0 in both.
- Opcode 0x0000007F: TRAP_EN=1 -> trap, cause 1, retired unchanged; TRAP_EN=0 -> PC+4, retired+1. ADDI x0 (0x00100013) -> reg_write=0.
- JAL x1 (0x008000EF) -> reg_write=1, wb_sel=2, pc_sel=2. Assert rst=0 mid-MEM -> next cycle FETCH, retired=0, all enables 0.
